dm_load_unit: RTL and testbench
===============================

// Module: dm_load_unit
// PURPOSE
//  Read-side companion of the data memory: accepts load requests (lw/lh/lhu/lb/lbu) from the
//  MEM stage and drives a synchronous-read word RAM port. It extracts the addressed byte/halfword,
//  zero/sign-extends it and returns it on a valid/ready response channel with misalignment flag.
//  Two-stage pipeline (issue, align), full throughput, loss-free under response back-pressure.
// PARAMETERS
//  ADDR_W   10   word-index width of RAM port (ram_addr = req_addr[ADDR_W+1:2])
//  DATA_W   32   word width; fixed at 32, other values unsupported
// PORTS
//  clk          in   1       clock, all state on posedge
//  reset        in   1       synchronous, active-high
//  req_valid    in   1       load request present
//  req_ready    out  1       unit accepts request this cycle
//  req_op       in   3       load type (LD_* codes, package)
//  req_addr     in   32      byte address
//  req_pc       in   32      PC of load instr, carried to response
//  ram_en       out  1       RAM read enable (combinational = accepted && !misaligned)
//  ram_addr     out  ADDR_W  RAM word index = req_addr[ADDR_W+1:2]
//  ram_rdata    in   32      RAM read data, valid the cycle after ram_en
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       consumer takes response
//  rsp_data     out  32      extended load result
//  rsp_misalign out  1       address misaligned for req_op
//  rsp_pc       out  32      PC of the responding load
// BEHAVIOUR
//  - Reset: s1_valid, buf_valid, rsp_valid, rsp_misalign = 0; rsp_data, rsp_pc = 0. Reset while
//    loads in flight drops them; no response emitted for them.
//  - Accept = req_valid && req_ready. req_ready = !s1_valid || s2_adv; s2_adv = !rsp_valid || rsp_ready.
//  - Latency: accept in cycle N -> ram_rdata in N+1 -> rsp_valid in N+2 (no stall). 1 load/cycle.
//  - S1 regs: op, addr[1:0], pc, misalign, s1_valid. Data source in S1 = buf_valid ? buf : ram_rdata.
//  - Stall: if s1_valid && !s2_adv && !buf_valid, latch ram_rdata into buf, buf_valid=1 (RAM data
//    is only valid one cycle). buf_valid clears when S1 advances. Never re-read RAM.
//  - rsp_* holds stable while rsp_valid && !rsp_ready.
//  - Misalign: LD_W addr[1:0]!=0, LD_H/LD_HU addr[0]!=0 -> ram_en=0, rsp_misalign=1, rsp_data=0.
//  - Extraction (little-endian, matches store side): byte k = word[8k+7:8k]; halfword at
//    addr[1] -> word[31:16], else word[15:0]. LD_B/LD_H sign-extend, LD_BU/LD_HU zero-extend.
//  - Reserved op codes (5..7): rsp_data = raw word, rsp_misalign=0.
//  - Simultaneous rsp_ready and new accept: S2 loads S1 result, S1 loads new req same edge.
// CONFIGURATION
//  LOAD_TRACE_EN defined: on each rsp handshake $display("%d@%h: $? <= *%h = %h", $time,
//    rsp_pc, word-aligned addr, rsp_data) (requires addr carried to S2); not defined: no
//    display, no extra state. Functional outputs identical either way.
// STRUCTURE
//  mem_pkg (shared with store path): LD_W=0, LD_H=1, LD_HU=2, LD_B=3, LD_BU=4 codes,
//    RAM word-index width, misalign check function.
//  Sub-module load_align: combinational (word, op, offset) -> extended data; reused by bypass.
// TESTING
//  1 word=32'h8899AABB at idx 4; LD_B @0x11 -> rsp_data=FFFFFFAA at N+2; LD_BU -> 000000AA.
//  2 LD_H @0x12 -> FFFF8899; LD_HU @0x10 -> 0000AABB; LD_W @0x10 -> 8899AABB, misalign=0.
//  3 LD_W @0x13 -> ram_en=0, rsp_misalign=1, rsp_data=0; LD_H @0x11 same flags.
//  4 3 back-to-back loads, rsp_ready=0 for 4 cycles: req_ready drops, all 3 responses in order,
//    data unchanged by RAM rewrites of those words during stall (buffer holds).
//  5 Reset asserted with 2 loads in flight -> rsp_valid=0 next cycle, no late responses.
//  6 Random op/addr/ready stream vs reference model: in-order, no drop/dup, 1/cycle when ready=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared data-memory definitions used by the load path (and the store path).
// Holds the load op codes, the RAM word-index width, the S1 pipeline record
// and the alignment check used to suppress RAM reads for misaligned loads.
package mem_pkg;

  localparam int RAM_IDX_W = 10;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  // Load in flight between issue and align.
  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] pc;
    logic        mis;
  } ld_s1_t;

  // Reserved codes have no alignment requirement.
  function automatic logic ld_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      LD_W:        mis = (off != 2'b00);
      LD_H, LD_HU: mis = off[0];
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of a
// little-endian 32-bit word and sign/zero-extends it.
// Ports:
//   word_i  - full RAM word
//   op_i    - load op code (LD_*); reserved codes pass the raw word
//   off_i   - byte offset within the word (addr[1:0])
//   data_o  - extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    case (op_i)
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data_o = {16'h0000, half_sel};
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {24'h000000, byte_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// Data-memory load unit. Accepts lw/lh/lhu/lb/lbu requests, drives a
// synchronous-read word RAM, aligns/extends the result and returns it on a
// valid/ready response channel. Two stages: S1 (issue, RAM read in flight)
// and S2 (response register). Full throughput; a one-word buffer catches RAM
// data when S1 stalls, since the RAM output is only valid for one cycle.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_op, req_addr, req_pc payload
//   ram_en, ram_addr      - RAM read port (ram_en suppressed for misaligned loads)
//   ram_rdata             - RAM data, valid the cycle after ram_en
//   rsp_valid/rsp_ready   - response handshake
//   rsp_data, rsp_misalign, rsp_pc - response payload
// Build option: LOAD_TRACE_EN prints each completed load (simulation trace).
module dm_load_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = RAM_IDX_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_pc,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_misalign,
  output logic [31:0]       rsp_pc
);

  logic              s1_valid_q, s1_valid_d;
  ld_s1_t            s1_q, s1_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_mis_q, rsp_mis_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;

  logic              s2_adv;
  logic              accept;
  logic              req_mis;
  logic [DATA_W-1:0] s1_word;
  logic [31:0]       s1_aligned;

  assign s2_adv    = !rsp_valid_q || rsp_ready;
  assign req_ready = !s1_valid_q || s2_adv;
  assign accept    = req_valid && req_ready;
  assign req_mis   = ld_misaligned(req_op, req_addr[1:0]);
  assign ram_en    = accept && !req_mis;
  assign ram_addr  = req_addr[ADDR_W+1:2];

  // Once S1 has stalled, the RAM output is stale; use the captured copy.
  assign s1_word = buf_valid_q ? buf_q : ram_rdata;

  load_align u_align (
    .word_i (s1_word),
    .op_i   (s1_q.op),
    .off_i  (s1_q.off),
    .data_o (s1_aligned)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_pc_d    = rsp_pc_q;

    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_data_d = s1_q.mis ? '0 : s1_aligned;
        rsp_mis_d  = s1_q.mis;
        rsp_pc_d   = s1_q.pc;
      end
    end

    if (s1_valid_q && !s2_adv && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_d       = ram_rdata;
    end else if (s1_valid_q && s2_adv) begin
      buf_valid_d = 1'b0;
    end

    if (req_ready) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_d = '{op: req_op, off: req_addr[1:0], pc: req_pc, mis: req_mis};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_pc_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      buf_valid_q <= buf_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_pc_q    <= rsp_pc_d;
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    s1_q  <= s1_d;
    buf_q <= buf_d;
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_misalign = rsp_mis_q;
  assign rsp_pc       = rsp_pc_q;

`ifdef LOAD_TRACE_EN
  logic [31:0] s1_waddr_q, rsp_waddr_q;

  always_ff @(posedge clk) begin
    if (accept) s1_waddr_q <= {req_addr[31:2], 2'b00};
    if (s2_adv && s1_valid_q) rsp_waddr_q <= s1_waddr_q;
    if (!reset && rsp_valid_q && rsp_ready)
      $display("%d@%h: $? <= *%h = %h", $time, rsp_pc_q, rsp_waddr_q, rsp_data_q);
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
`endif

endmodule

// File: tb/tb_dm_load_unit.sv
module tb_dm_load_unit;
  import mem_pkg::*;

  localparam int AW = 10;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [31:0]   req_addr;
  logic [31:0]   req_pc;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_misalign;
  logic [31:0]   rsp_pc;

  dm_load_unit #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_pc       (req_pc),
    .ram_en       (ram_en),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_misalign (rsp_misalign),
    .rsp_pc       (rsp_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM; output is garbage in cycles without a read.
  logic [31:0] mem [0:1023];
  always @(posedge clk) ram_rdata <= ram_en ? mem[ram_addr] : $urandom;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_load(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] w, output logic [31:0] d,
                                   output logic m);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a[1:0]));
    h = a[1] ? w[31:16] : w[15:0];
    m = 1'b0;
    case (op)
      3'd0: begin m = (a[1:0] != 2'b00); d = w; end
      3'd1: begin m = a[0]; d = {{16{h[15]}}, h}; end
      3'd2: begin m = a[0]; d = {16'h0, h}; end
      3'd3: d = {{24{b[7]}}, b};
      3'd4: d = {24'h0, b};
      default: d = w;
    endcase
    if (m) d = 32'h0;
  endfunction

  // Monitor: scoreboard push on accept, pop on response, hold-stability check.
  logic        hold_q = 1'b0;
  logic [31:0] hold_data, hold_pc;
  logic        hold_mis;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] d;
    logic        m;
    if (reset) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, hold_data);
        chk("hold_pc", rsp_pc, hold_pc);
        chk("hold_mis", rsp_misalign, hold_mis);
      end
      hold_q    = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
      hold_pc   = rsp_pc;
      hold_mis  = rsp_misalign;

      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_misalign", rsp_misalign, e.mis);
          chk("rsp_pc", rsp_pc, e.pc);
        end
      end

      if (req_valid && req_ready) begin
        ref_load(req_op, req_addr, mem[req_addr[11:2]], d, m);
        chk("ram_en", ram_en, !m);
        if (!m) chk("ram_addr", ram_addr, req_addr[11:2]);
        sb.push_back('{data: d, mis: m, pc: req_pc});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] pc, input bit immed);
    int n;
    bit acc;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_pc    = pc;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 40);
    if (!acc) chk("issue_timeout", 0, 1);
    else if (immed) chk("accept_cycles", n, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[4] = 32'h8899AABB;
    mem[5] = 32'h11223344;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_pc = 32'h0; rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_pc", rsp_pc, 0);
    chk("reset_rsp_mis", rsp_misalign, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Latency and byte extraction
    issue(LD_B, 32'h11, 32'h100, 1'b1);
    @(negedge clk);
    chk("latency_n1", rsp_valid, 0);
    @(negedge clk);
    chk("latency_n2", rsp_valid, 1);
    chk("lb_value", rsp_data, 32'hFFFFFFAA);
    @(posedge clk); #1;

    // Back-to-back stream of every op incl. misaligned and reserved
    issue(LD_BU, 32'h11, 32'h104, 1'b1);
    issue(LD_H,  32'h12, 32'h108, 1'b1);
    issue(LD_HU, 32'h10, 32'h10C, 1'b1);
    issue(LD_W,  32'h10, 32'h110, 1'b1);
    issue(LD_W,  32'h13, 32'h114, 1'b1);
    issue(LD_H,  32'h11, 32'h118, 1'b1);
    issue(3'd5,  32'h13, 32'h11C, 1'b1);
    issue(LD_HU, 32'h17, 32'h120, 1'b1);
    drain();

    // Back-pressure: RAM rewritten while loads wait in the pipeline
    rsp_ready = 1'b0;
    fork
      begin
        issue(LD_W,  32'h10, 32'h200, 1'b0);
        issue(LD_HU, 32'h16, 32'h204, 1'b0);
        issue(LD_B,  32'h13, 32'h208, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'hCAFEF00D;
        @(negedge clk);
        chk("stall_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset with two loads in flight
    issue(LD_W, 32'h14, 32'h300, 1'b1);
    issue(LD_B, 32'h15, 32'h304, 1'b1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle", rsp_valid, 0);
      @(posedge clk); #1;
    end

    // Random stream against the reference model
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 3'($urandom_range(0, 7));
      req_addr  = $urandom;
      req_pc    = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 1023)] = $urandom;
      @(posedge clk); #1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
